bit_serial_adder_ctrl: RTL and testbench

- Sequences one shared 1-bit full-adder cell over WIDTH cycles to perform a multi-bit add, LSB first.
- Trades latency for area in small arithmetic datapaths.
- Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
- Sits between an operand source (register file or test harness) and a result consumer.

---
 rtl/bsa_pkg.sv | 17 +
 rtl/bit_serial_adder_ctrl_if.sv | 41 ++++
 rtl/bit_serial_adder_ctrl_fa_cell.sv | 14 +
 rtl/bit_serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bsa_pkg.sv
// Shared constants for the bit-serial adder controller.
// Optional subtract mode is enabled by defining BSA_SUBTRACT_EN.
package bsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEF_WIDTH = 8;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Port sub exists only when BSA_SUBTRACT_EN is defined.
interface bsa_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef BSA_SUBTRACT_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;

`ifdef BSA_SUBTRACT_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, c, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, c, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, c, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, c, ovf
  );
`endif

endinterface

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// Combinational 1-bit full adder shared across all bit positions.
// sum = x^y^ci, co = majority(x, y, ci).
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one fa_cell iterated WIDTH cycles, LSB first.
// Define BSA_SUBTRACT_EN to add the sub input (a - b).
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  bsa_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("bit_serial_adder_ctrl: WIDTH out of range");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             c_q;
  logic             ovf_q;
  logic             sum;
  logic             co;
  logic             is_idle;
  logic             is_run;
  logic             is_done;
  logic [WIDTH-1:0] b_ld;
  logic             ci_ld;

  assign is_idle = (state == ST_IDLE);
  assign is_run  = (state == ST_RUN);
  assign is_done = (state == ST_DONE);

`ifdef BSA_SUBTRACT_EN
  // Two's-complement subtract: invert b and inject a carry of one.
  assign b_ld  = bus.sub ? ~bus.b : bus.b;
  assign ci_ld = bus.sub | bus.cin;
`else
  assign b_ld  = bus.b;
  assign ci_ld = bus.cin;
`endif

  fa_cell u_fa (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .ci  (carry),
    .sum (sum),
    .co  (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= b_ld;
            carry <= ci_ld;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        is_run: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= {sum, s_sh[WIDTH-1:1]};
          carry <= co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            c_q   <= co;
            // carry into the MSB is the flop value before this update
            ovf_q <= carry ^ co;
            state <= ST_DONE;
          end
        end
        is_done: begin
          if (bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = is_idle;
  assign bus.out_valid = is_done;
  assign bus.s         = s_sh;
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Randomized self-checking bench for bit_serial_adder_ctrl.
// Reference model uses plain integer arithmetic on whole words.
`timescale 1ns/1ps
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic         ovf;
    logic         c;
    logic [W-1:0] s;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  res_t q[$];

  bsa_if #(.WIDTH(W)) bus ();

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    res_t r;
    logic [W-1:0] yy;
    logic [W:0]   full;
    int           cc;
    yy = sb ? ~y : y;
    cc = sb ? 1 : int'(ci);
    full = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
    r.s = full[W-1:0];
    r.c = full[W];
    r.ovf = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub);
    bus.a   = ta;
    bus.b   = tb;
    bus.cin = tcin;
`ifdef BSA_SUBTRACT_EN
    bus.sub = tsub;
`endif
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic tsub, input int hold);
    res_t e;
    int   lat;
    logic busy;
    e = model(ta, tb, tcin, tsub);
    bus.out_ready = 1'b0;
    drive(ta, tb, tcin, tsub);
    bus.in_valid = 1'b1;
    chk("idle_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    busy = 1'b0;
    while (!bus.out_valid && lat < 4*W) begin
      if (bus.in_ready) busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W);
    chk("run_in_ready", busy, 0);
    chk("s", bus.s, e.s);
    chk("c", bus.c, e.c);
    chk("ovf", bus.ovf, e.ovf);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_res", {bus.ovf, bus.c, bus.s}, e);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("ret_valid", bus.out_valid, 0);
    chk("ret_in_ready", bus.in_ready, 1);
    chk("idle_res", {bus.ovf, bus.c, bus.s}, e);
  endtask

  task automatic reset_mid_op;
    logic bad;
    bus.out_ready = 1'b0;
    drive(8'hFF, 8'h00, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_res", {bus.ovf, bus.c, bus.s}, 0);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3*W) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) bad = 1'b1;
    end
    bus.out_ready = 1'b0;
    chk("rst_no_stale", bad, 0);
  endtask

  task automatic back_to_back;
    res_t e;
    int   last_acc;
    int   nacc;
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic tc;
    logic ts;
    last_acc = -1;
    nacc = 0;
    ta = W'($urandom); tb = W'($urandom);
    tc = 1'($urandom); ts = 1'($urandom);
`ifndef BSA_SUBTRACT_EN
    ts = 1'b0;
`endif
    drive(ta, tb, tc, ts);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 6*(W+2); cyc++) begin
      if (bus.out_valid) begin
        if (q.size() == 0) chk("b2b_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("b2b_res", {bus.ovf, bus.c, bus.s}, e);
        end
      end
      if (bus.in_ready) begin
        q.push_back(model(ta, tb, tc, ts));
        if (last_acc >= 0) chk("b2b_spacing", cyc - last_acc, W+2);
        last_acc = cyc;
        nacc++;
      end else begin
        ta = W'($urandom); tb = W'($urandom);
        tc = 1'($urandom);
`ifdef BSA_SUBTRACT_EN
        ts = 1'($urandom);
`endif
        drive(ta, tb, tc, ts);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 3*W && q.size() > 0; cyc++) begin
      if (bus.out_valid) begin
        e = q.pop_front();
        chk("b2b_res", {bus.ovf, bus.c, bus.s}, e);
      end
      @(posedge clk); #1;
    end
    chk("b2b_drain", q.size(), 0);
    chk("b2b_count", nacc >= 5, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    #3;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_res", {bus.ovf, bus.c, bus.s}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 5);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 1);
`ifdef BSA_SUBTRACT_EN
    do_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 0);
    do_op(8'h80, 8'h80, 1'b1, 1'b0, 0);
`endif
    reset_mid_op();
    back_to_back();

    for (int i = 0; i < 25; i++) begin
`ifdef BSA_SUBTRACT_EN
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
`else
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0,
            int'($urandom_range(0, 3)));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
